ras_checkpoint_stack: RTL and testbench

RAS_CHECKPOINT_STACK -- requirements
Module: ras_checkpoint_stack

---
 rtl/ras_checkpoint_stack.sv | 167 ++++++++++++++++
 tb/tb_ras_checkpoint_stack.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_checkpoint_stack.sv
// Return-address stack with multi-lane push/pop arbitration and FIFO-ordered checkpoints for mispredict recovery.
// Single-cycle update latency; restore wins over push/pop/checkpoint, and reset wins over everything.
module ras_checkpoint_stack #(
  parameter int FETCH_WIDTH = 2,
  parameter int RAS_DEPTH   = 16,
  parameter int CKPT_NUM    = 8,
  parameter int PC_WIDTH    = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [FETCH_WIDTH-1:0]                pushValid,
  input  logic [FETCH_WIDTH-1:0]                popValid,
  input  logic [FETCH_WIDTH-1:0][PC_WIDTH-1:0]  pushAddr,
  output logic [PC_WIDTH-1:0]                   rasOut,
  output logic                                  rasEmpty,
  input  logic                                  ckptReq,
  output logic                                  ckptAck,
  output logic [$clog2(CKPT_NUM)-1:0]           ckptId,
  output logic                                  ckptFull,
  input  logic                                  restoreValid,
  input  logic [$clog2(CKPT_NUM)-1:0]           restoreId,
  input  logic                                  releaseValid
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(CKPT_NUM);

  typedef logic [PW-1:0]       ptr_t;
  typedef logic [PW:0]         cnt_t;
  typedef logic [CW-1:0]       cid_t;
  typedef logic [CW:0]         occ_t;
  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam cnt_t DEPTH_C = cnt_t'(RAS_DEPTH);
  localparam occ_t NUM_C   = occ_t'(CKPT_NUM);

  pc_t  entry_q [RAS_DEPTH];
  ptr_t ptr_q, ptr_d;
  cnt_t cnt_q, cnt_d;

  ptr_t ck_ptr_q [CKPT_NUM];
  cnt_t ck_cnt_q [CKPT_NUM];
  pc_t  ck_top_q [CKPT_NUM];

  cid_t head_q, head_d;
  cid_t tail_q, tail_d;
  occ_t occ_q, occ_d;

  logic win_vld, win_push, win_pop;
  pc_t  win_addr;

  logic wr_en;
  ptr_t wr_idx;
  pc_t  wr_dat;

  ptr_t ptr_m1, ptr_d_m1;
  pc_t  top_d;
  logic rel_en;
  cid_t occ_diff;

  // Lowest-index lane carrying any request wins; the rest are dropped.
  always_comb begin
    win_vld  = 1'b0;
    win_push = 1'b0;
    win_pop  = 1'b0;
    win_addr = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!win_vld && (pushValid[i] || popValid[i])) begin
        win_vld  = 1'b1;
        win_push = pushValid[i];
        win_pop  = popValid[i];
        win_addr = pushAddr[i];
      end
    end
  end

  assign ptr_m1 = ptr_q - ptr_t'(1);

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    wr_dat = win_addr;
    if (restoreValid) begin
      ptr_d  = ck_ptr_q[restoreId];
      cnt_d  = ck_cnt_q[restoreId];
      wr_en  = 1'b1;
      wr_idx = ck_ptr_q[restoreId] - ptr_t'(1);
      wr_dat = ck_top_q[restoreId];
    end else if (win_vld) begin
      if (win_push && win_pop && (cnt_q != '0)) begin
        wr_en  = 1'b1;
        wr_idx = ptr_m1;
      end else if (win_push) begin
        wr_en  = 1'b1;
        wr_idx = ptr_q;
        ptr_d  = ptr_q + ptr_t'(1);
        if (cnt_q != DEPTH_C) begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end else if (cnt_q != '0) begin
        ptr_d = ptr_m1;
        cnt_d = cnt_q - cnt_t'(1);
      end
    end
  end

  // Top of stack as it will look after this cycle's update, for checkpoint capture.
  assign ptr_d_m1 = ptr_d - ptr_t'(1);
  assign top_d    = (wr_en && (wr_idx == ptr_d_m1)) ? wr_dat : entry_q[ptr_d_m1];

  assign ckptFull = (occ_q == NUM_C);
  assign ckptAck  = ckptReq && !ckptFull && !restoreValid && !rst;
  assign ckptId   = tail_q;
  assign rel_en   = releaseValid && (occ_q != '0);

  always_comb begin
    head_d   = head_q + cid_t'(rel_en);
    tail_d   = tail_q;
    occ_d    = occ_q;
    occ_diff = '0;
    if (restoreValid) begin
      // restoreId survives, so an all-equal head/tail here means full, never empty.
      tail_d   = restoreId + cid_t'(1);
      occ_diff = tail_d - head_d;
      occ_d    = (occ_diff == '0) ? NUM_C : occ_t'(occ_diff);
    end else begin
      tail_d = tail_q + cid_t'(ckptAck);
      occ_d  = occ_q + occ_t'(ckptAck) - occ_t'(rel_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      if (wr_en) begin
        entry_q[wr_idx] <= wr_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ckptAck) begin
      ck_ptr_q[tail_q] <= ptr_d;
      ck_cnt_q[tail_q] <= cnt_d;
      ck_top_q[tail_q] <= top_d;
    end
  end

  assign rasOut   = entry_q[ptr_m1];
  assign rasEmpty = (cnt_q == '0);

endmodule

// File: tb/tb_ras_checkpoint_stack.sv
// Directed bench for ras_checkpoint_stack (2 lanes, 4-deep stack, 4 checkpoint slots).
// Expected values are hand-derived per step; a shadow of checkpoint occupancy guards protocol misuse.
module tb_ras_checkpoint_stack;

  localparam int FW = 2;
  localparam int RD = 4;
  localparam int CN = 4;
  localparam int PCW = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [FW-1:0]            pushValid;
  logic [FW-1:0]            popValid;
  logic [FW-1:0][PCW-1:0]   pushAddr;
  logic [PCW-1:0]           rasOut;
  logic                     rasEmpty;
  logic                     ckptReq;
  logic                     ckptAck;
  logic [1:0]               ckptId;
  logic                     ckptFull;
  logic                     restoreValid;
  logic [1:0]               restoreId;
  logic                     releaseValid;

  int n_cmp = 0;
  int n_bad = 0;

  ras_checkpoint_stack #(
    .FETCH_WIDTH(FW), .RAS_DEPTH(RD), .CKPT_NUM(CN), .PC_WIDTH(PCW)
  ) dut (
    .clk(clk), .rst(rst),
    .pushValid(pushValid), .popValid(popValid), .pushAddr(pushAddr),
    .rasOut(rasOut), .rasEmpty(rasEmpty),
    .ckptReq(ckptReq), .ckptAck(ckptAck), .ckptId(ckptId), .ckptFull(ckptFull),
    .restoreValid(restoreValid), .restoreId(restoreId), .releaseValid(releaseValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pushValid    = '0;
    popValid     = '0;
    pushAddr     = '0;
    ckptReq      = 1'b0;
    restoreValid = 1'b0;
    restoreId    = '0;
    releaseValid = 1'b0;
  endtask

  task automatic do_push(input int lane, input logic [31:0] a);
    clr();
    pushValid[lane] = 1'b1;
    pushAddr[lane]  = a;
    cyc();
    clr();
  endtask

  task automatic do_pop(input int lane);
    clr();
    popValid[lane] = 1'b1;
    cyc();
    clr();
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Shadow of checkpoint head/occupancy, used only to flag illegal restore/release combinations.
  int m_head = 0;
  int m_occ  = 0;

  function automatic bit slot_live(input int s);
    return (((s - m_head) % CN + CN) % CN) < m_occ;
  endfunction

  always @(posedge clk) begin
    int h, o, d;
    bit ack, rel;
    if (rst) begin
      m_head <= 0;
      m_occ  <= 0;
    end else begin
      if (restoreValid) begin
        assert (slot_live(int'(restoreId)) &&
                !(releaseValid && m_occ > 0 && int'(restoreId) == m_head))
          else $error("FAIL protocol: restore of slot %0d with head %0d occ %0d", restoreId, m_head, m_occ);
      end
      ack = ckptReq && (m_occ != CN) && !restoreValid;
      rel = releaseValid && (m_occ != 0);
      h   = (m_head + int'(rel)) % CN;
      if (restoreValid) begin
        d = (((int'(restoreId) + 1 - h) % CN) + CN) % CN;
        o = (d == 0) ? CN : d;
      end else begin
        o = m_occ + int'(ack) - int'(rel);
      end
      m_head <= h;
      m_occ  <= o;
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    ckptReq = 1'b1;
    cyc();
    cyc();
    check("rst_rasOut", rasOut, 32'h0);
    check("rst_empty", 32'(rasEmpty), 32'd1);
    check("rst_full", 32'(ckptFull), 32'd0);
    check("rst_ack_gated", 32'(ckptAck), 32'd0);
    check("rst_id", 32'(ckptId), 32'd0);
    rst = 1'b0;
    clr();

    // Basic push/pop visibility
    do_push(0, 32'h100);
    check("push1_top", rasOut, 32'h100);
    check("push1_empty", 32'(rasEmpty), 32'd0);
    do_push(0, 32'h200);
    do_push(0, 32'h300);
    check("push3_top", rasOut, 32'h300);
    do_pop(0);
    check("pop_top", rasOut, 32'h200);
    check("pop_empty", 32'(rasEmpty), 32'd0);

    // Lane0 pop wins over lane1 push
    clr();
    popValid[0]  = 1'b1;
    pushValid[1] = 1'b1;
    pushAddr[1]  = 32'h400;
    cyc();
    clr();
    check("arb_top", rasOut, 32'h100);
    do_pop(0);
    check("arb_no_push", 32'(rasEmpty), 32'd1);

    // Overflow by one, then drain
    do_push(0, 32'hA0);
    do_push(0, 32'hB0);
    do_push(0, 32'hC0);
    do_push(0, 32'hD0);
    do_push(0, 32'hE0);
    check("ovf_top_E", rasOut, 32'hE0);
    do_pop(0);
    check("ovf_top_D", rasOut, 32'hD0);
    do_pop(1);
    check("ovf_top_C", rasOut, 32'hC0);
    do_pop(0);
    check("ovf_top_B", rasOut, 32'hB0);
    check("ovf_not_empty", 32'(rasEmpty), 32'd0);
    do_pop(0);
    check("ovf_drained", 32'(rasEmpty), 32'd1);
    do_pop(0);
    check("underflow_empty", 32'(rasEmpty), 32'd1);
    do_push(0, 32'h55);
    check("after_uf_top", rasOut, 32'h55);
    do_pop(0);
    check("after_uf_empty", 32'(rasEmpty), 32'd1);

    // Same-lane push+pop replaces top; on empty it acts as a plain push
    do_push(0, 32'h11);
    clr();
    pushValid[1] = 1'b1; popValid[1] = 1'b1; pushAddr[1] = 32'h22;
    cyc();
    clr();
    check("replace_top", rasOut, 32'h22);
    do_pop(0);
    check("replace_count", 32'(rasEmpty), 32'd1);
    clr();
    pushValid[0] = 1'b1; popValid[0] = 1'b1; pushAddr[0] = 32'h33;
    cyc();
    clr();
    check("pp_empty_top", rasOut, 32'h33);
    check("pp_empty_flag", 32'(rasEmpty), 32'd0);
    do_pop(0);

    // Checkpoint, corrupt top, restore
    do_push(0, 32'h100);
    do_push(0, 32'h200);
    clr();
    ckptReq = 1'b1;
    #1;
    check("ck_ack", 32'(ckptAck), 32'd1);
    check("ck_id0", 32'(ckptId), 32'd0);
    cyc();
    clr();
    do_pop(0);
    check("ck_pop_top", rasOut, 32'h100);
    do_push(0, 32'h900);
    check("ck_push_top", rasOut, 32'h900);
    clr();
    restoreValid = 1'b1;
    restoreId    = 2'd0;
    pushValid[0] = 1'b1;
    pushAddr[0]  = 32'hBAD;
    ckptReq      = 1'b1;
    #1;
    check("rs_ack_blocked", 32'(ckptAck), 32'd0);
    cyc();
    clr();
    check("rs_top", rasOut, 32'h200);
    check("rs_tail", 32'(ckptId), 32'd1);
    do_pop(0);
    check("rs_second", rasOut, 32'h100);
    do_pop(0);
    check("rs_count2", 32'(rasEmpty), 32'd1);
    clr();
    releaseValid = 1'b1;
    cyc();
    clr();

    // Checkpoint FIFO fill, full drop, release, wrap
    do_reset();
    clr();
    releaseValid = 1'b1;
    cyc();
    clr();
    for (int i = 0; i < CN; i++) begin
      ckptReq = 1'b1;
      #1;
      check($sformatf("fill_id%0d", i), 32'(ckptId), 32'(i));
      cyc();
      clr();
    end
    check("fill_full", 32'(ckptFull), 32'd1);
    ckptReq = 1'b1;
    #1;
    check("full_drop_ack", 32'(ckptAck), 32'd0);
    cyc();
    clr();
    check("full_drop_tail", 32'(ckptId), 32'd0);
    check("full_drop_full", 32'(ckptFull), 32'd1);
    releaseValid = 1'b1;
    cyc();
    clr();
    check("rel_not_full", 32'(ckptFull), 32'd0);
    ckptReq = 1'b1;
    #1;
    check("wrap_ack", 32'(ckptAck), 32'd1);
    check("wrap_id", 32'(ckptId), 32'd0);
    cyc();
    clr();
    check("wrap_full", 32'(ckptFull), 32'd1);

    // Reset mid-operation overrides restore, pushes and checkpoint
    do_push(0, 32'h71);
    do_push(0, 32'h72);
    do_push(0, 32'h73);
    do_push(0, 32'h74);
    check("pre_rst_top", rasOut, 32'h74);
    clr();
    rst          = 1'b1;
    restoreValid = 1'b1;
    restoreId    = 2'd1;
    pushValid    = 2'b11;
    pushAddr[0]  = 32'hDEAD;
    pushAddr[1]  = 32'hBEEF;
    ckptReq      = 1'b1;
    cyc();
    check("mid_rst_ack", 32'(ckptAck), 32'd0);
    rst = 1'b0;
    clr();
    check("mid_rst_top", rasOut, 32'h0);
    check("mid_rst_empty", 32'(rasEmpty), 32'd1);
    check("mid_rst_full", 32'(ckptFull), 32'd0);
    check("mid_rst_id", 32'(ckptId), 32'd0);
    check("mid_rst_ackidle", 32'(ckptAck), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
